fm_demod_track: RTL and testbench



---
 rtl/fm_demod_track.sv | 154 +++++++++++++++
 tb/tb_fm_demod_track.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fm_demod_track.sv
// FM demodulator with NCO square-wave reference, sign-multiply detector,
// power-of-two integrate-and-dump averager, optional frequency tracking and lock flag.
module fm_demod_track #(
    parameter int DATA_W       = 16,
    parameter int PHASE_W      = 32,
    parameter int MAX_LOG2_DEC = 16,
    parameter int LOCK_THR     = 256,
    parameter int LOCK_CNT     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_W-1:0]   modulated,
    input  logic [PHASE_W-1:0]  ctr_ctrl,
    input  logic [4:0]          sample_rate,
    input  logic                mode,
    input  logic [3:0]          track_shift,
    output logic [DATA_W-1:0]   demodulated,
    output logic                demod_valid,
    output logic [PHASE_W-1:0]  freq_offset,
    output logic                lock
);
    localparam int ACC_W = DATA_W + MAX_LOG2_DEC;
    localparam int CNT_W = MAX_LOG2_DEC + 1;
    localparam int DEC_W = $clog2(MAX_LOG2_DEC + 1);
    localparam int EXT_W = PHASE_W + DATA_W + 16;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic signed [EXT_W-1:0] SAT_POS =
        {{(EXT_W-PHASE_W+1){1'b0}}, 1'b1, {(PHASE_W-2){1'b0}}};
    localparam logic signed [EXT_W-1:0] SAT_NEG = -SAT_POS;
    localparam logic [DATA_W:0] THR = (DATA_W+1)'(LOCK_THR);

    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic [DATA_W-1:0]         pd_q, pd_d;
    logic                      pd_v_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DEC_W-1:0]          dec_q, dec_d;
    logic [DATA_W-1:0]         demod_q, demod_d;
    logic                      valid_q, valid_d;
    logic [PHASE_W-1:0]        foff_q, foff_d;
    logic [LCK_W-1:0]          lcnt_q, lcnt_d;
    logic                      lock_q, lock_d;

    logic [DEC_W-1:0]          dec_req;
    logic [DEC_W-1:0]          dec_cur;
    logic                      blk_last;
    logic signed [ACC_W-1:0]   sum;
    logic [DATA_W-1:0]         new_demod;
    logic signed [EXT_W-1:0]   ext_demod;
    logic signed [EXT_W-1:0]   ext_foff;
    logic signed [EXT_W-1:0]   trk_sum;
    logic [DATA_W:0]           mag;

    // NCO and detector stage: both advance only on enabled samples.
    always_comb begin
        phase_d = phase_q;
        pd_d    = pd_q;
        if (en) begin
            phase_d = phase_q + ctr_ctrl + foff_q;
            pd_d    = phase_q[PHASE_W-1] ? ~modulated : modulated;
        end
    end

    // The decimation exponent is only sampled at a block start so a block never changes length.
    always_comb begin
        dec_req  = (32'(sample_rate) > 32'(MAX_LOG2_DEC)) ? DEC_W'(MAX_LOG2_DEC)
                                                          : DEC_W'(sample_rate);
        dec_cur  = (cnt_q == '0) ? dec_req : dec_q;
        blk_last = (cnt_q == ((CNT_W'(1) << dec_cur) - CNT_W'(1)));
        sum      = acc_q + {{MAX_LOG2_DEC{pd_q[DATA_W-1]}}, pd_q};
        new_demod = DATA_W'(sum >>> dec_cur);
        ext_demod = {{(EXT_W-DATA_W){new_demod[DATA_W-1]}}, new_demod};
        ext_foff  = {{(EXT_W-PHASE_W){foff_q[PHASE_W-1]}}, foff_q};
        trk_sum   = ext_foff + (ext_demod <<< track_shift);
        mag       = new_demod[DATA_W-1] ? -{1'b1, new_demod} : {1'b0, new_demod};
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        demod_d = demod_q;
        valid_d = 1'b0;
        foff_d  = foff_q;
        lcnt_d  = lcnt_q;
        if (pd_v_q) begin
            if (cnt_q == '0) begin
                dec_d = dec_req;
            end
            if (blk_last) begin
                acc_d   = '0;
                cnt_d   = '0;
                demod_d = new_demod;
                valid_d = 1'b1;
                if (trk_sum > SAT_POS) begin
                    foff_d = PHASE_W'(SAT_POS);
                end else if (trk_sum < SAT_NEG) begin
                    foff_d = PHASE_W'(SAT_NEG);
                end else begin
                    foff_d = PHASE_W'(trk_sum);
                end
                if (mag < THR) begin
                    lcnt_d = (lcnt_q == LCK_W'(LOCK_CNT)) ? lcnt_q : lcnt_q + LCK_W'(1);
                end else begin
                    lcnt_d = '0;
                end
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Open loop forces the correction and lock state back to idle.
        if (!mode) begin
            foff_d = '0;
            lcnt_d = '0;
        end
        lock_d = mode && (lcnt_q == LCK_W'(LOCK_CNT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            pd_q    <= '0;
            pd_v_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= '0;
            demod_q <= '0;
            valid_q <= 1'b0;
            foff_q  <= '0;
            lcnt_q  <= '0;
            lock_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pd_q    <= pd_d;
            pd_v_q  <= en;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            demod_q <= demod_d;
            valid_q <= valid_d;
            foff_q  <= foff_d;
            lcnt_q  <= lcnt_d;
            lock_q  <= lock_d;
        end
    end

    assign demodulated = demod_q;
    assign demod_valid = valid_q;
    assign freq_offset = foff_q;
    assign lock        = lock_q;
endmodule

// File: tb/tb_fm_demod_track.sv
// Directed bench for fm_demod_track: averaging, NCO sign flip, tracking saturation,
// decimation clamping, mid-block reset and lock behaviour.
module tb_fm_demod_track;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] modulated;
    logic [31:0] ctr_ctrl;
    logic [4:0]  sample_rate;
    logic        mode;
    logic [3:0]  track_shift;
    logic [15:0] demodulated;
    logic        demod_valid;
    logic [31:0] freq_offset;
    logic        lock;

    int checks = 0;
    int errors = 0;

    fm_demod_track dut (
        .clk(clk), .rst(rst), .en(en), .modulated(modulated), .ctr_ctrl(ctr_ctrl),
        .sample_rate(sample_rate), .mode(mode), .track_shift(track_shift),
        .demodulated(demodulated), .demod_valid(demod_valid),
        .freq_offset(freq_offset), .lock(lock)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    int nvalid;

    initial begin
        rst = 1'b1; en = 1'b1; modulated = 16'd1000; ctr_ctrl = 32'd0;
        sample_rate = 5'd2; mode = 1'b0; track_shift = 4'd0;

        // 1: constant input, open loop, blocks of 4
        do_reset();
        check("rst_demod", demodulated, 0);
        check("rst_valid", demod_valid, 0);
        check("rst_foff", freq_offset, 0);
        check("rst_lock", lock, 0);
        for (int i = 1; i <= 13; i++) begin
            step(1);
            check($sformatf("t1_valid_%0d", i), demod_valid, (i == 5 || i == 9 || i == 13) ? 1 : 0);
            if (i == 5) check("t1_demod", demodulated, 16'd1000);
        end
        check("t1_foff", freq_offset, 0);

        // 2: half-rate reference, floor of -0.5
        ctr_ctrl = 32'h8000_0000;
        do_reset();
        step(4);
        check("t2_valid_early", demod_valid, 0);
        step(1);
        check("t2_valid", demod_valid, 1);
        check("t2_demod", demodulated, 16'hFFFF);
        step(4);
        check("t2_valid2", demod_valid, 1);
        check("t2_demod2", demodulated, 16'hFFFF);

        // 3a: tracking steps of 100<<4, then open loop clears the offset
        ctr_ctrl = 32'd0; mode = 1'b1; track_shift = 4'd4; modulated = 16'd100; sample_rate = 5'd0;
        do_reset();
        step(2);
        check("t3_valid", demod_valid, 1);
        check("t3_demod", demodulated, 16'd100);
        check("t3_foff1", freq_offset, 32'd1600);
        step(1);
        check("t3_foff2", freq_offset, 32'd3200);
        step(1);
        check("t3_foff3", freq_offset, 32'd4800);
        check("t3_lock", lock, 0);
        mode = 1'b0;
        step(1);
        check("t3_foff_clr", freq_offset, 0);

        // 3b: large gain saturates, then the shifted NCO flips the reference
        mode = 1'b1; track_shift = 4'd15; modulated = 16'd32767;
        do_reset();
        step(2);
        check("t3b_foff2", freq_offset, 32'h3FFF_8000);
        step(1);
        check("t3b_foff3", freq_offset, 32'h4000_0000);
        step(3);
        check("t3b_foff6", freq_offset, 32'h4000_0000);
        check("t3b_lock", lock, 0);
        step(1);
        check("t3b_demod7", demodulated, 16'h8000);
        check("t3b_foff7", freq_offset, 0);

        // 4a: exponent 31 clamps to 16
        mode = 1'b0; track_shift = 4'd0; modulated = 16'd1000; sample_rate = 5'd31;
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 65536; i++) begin
            step(1);
            if (demod_valid) nvalid++;
        end
        check("t4_no_early_valid", nvalid, 0);
        step(1);
        check("t4_valid_65536", demod_valid, 1);
        check("t4_demod", demodulated, 16'd1000);

        // 4b: decimation change mid-block applies to the next block
        sample_rate = 5'd2;
        do_reset();
        step(2);
        sample_rate = 5'd0;
        step(2);
        check("t4b_valid4", demod_valid, 0);
        step(1);
        check("t4b_valid5", demod_valid, 1);
        step(1);
        check("t4b_valid6", demod_valid, 1);
        step(1);
        check("t4b_valid7", demod_valid, 1);
        check("t4b_demod", demodulated, 16'd1000);

        // 5: reset mid-block discards the partial sum
        sample_rate = 5'd2;
        step(2);
        do_reset();
        check("t5_demod_rst", demodulated, 0);
        check("t5_valid_rst", demod_valid, 0);
        step(4);
        check("t5_valid4", demod_valid, 0);
        step(1);
        check("t5_valid5", demod_valid, 1);
        check("t5_demod", demodulated, 16'd1000);

        // 6: lock acquisition, loss, and en pause
        mode = 1'b1; track_shift = 4'd0; modulated = 16'd10; sample_rate = 5'd0;
        do_reset();
        step(9);
        check("t6_valid9", demod_valid, 1);
        check("t6_lock9", lock, 0);
        step(1);
        check("t6_lock10", lock, 1);
        modulated = 16'd1000;
        step(1);
        modulated = 16'd10;
        step(1);
        check("t6_demod_big", demodulated, 16'd1000);
        check("t6_lock12", lock, 1);
        step(1);
        check("t6_lock13", lock, 0);
        en = 1'b0;
        step(1);
        check("t6_valid14", demod_valid, 1);
        step(5);
        check("t6_pause_valid", demod_valid, 0);
        check("t6_pause_foff", freq_offset, 32'd1120);
        en = 1'b1;
        step(1);
        check("t6_valid20", demod_valid, 0);
        step(1);
        check("t6_valid21", demod_valid, 1);
        check("t6_demod21", demodulated, 16'd10);
        check("t6_foff21", freq_offset, 32'd1130);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
